uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter half of the UART block: takes one byte per valid/ready handshake and shifts it out on uart_txd as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits inside the uart top next to the receiver, which drives tx_data/tx_valid in loopback or echo use.
- Shares SYS_PERIOD/BPS timing with the receiver so both ends agree on bit period.

Parameters:
- SYS_PERIOD, 50000000, system clock frequency in Hz.
- BPS, 115200, line rate in bits per second.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_busy  output  1  a frame is on the line (start through last stop bit).
- tx_done  output  1  one-cycle pulse when a frame completes.
- uart_txd  output  1  serial line, idle high, registered.

Behaviour:
- Reset values (while rst_n=0): uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0. Reset mid-frame aborts immediately and drives the line high; no partial-frame recovery.
- BIT_CYCLES = SYS_PERIOD/BPS, using integer truncation (434 at defaults). Every line bit lasts exactly BIT_CYCLES clocks.
- Bit-period counter width = clog2(BIT_CYCLES). It counts 0..BIT_CYCLES-1, then wraps to 0 and emits bit_tick. It is held at 0 in IDLE.
- Accept: a byte is accepted on a rising edge where tx_valid=1 and tx_ready=1. tx_data is latched into the shift register. tx_valid is ignored at all other times; no buffering and no overflow flag.
- tx_ready = (state==IDLE). It is combinational from the registered state.
- State machine:
  - IDLE: uart_txd=1. On accept, go to START.
  - START: uart_txd=0 from the clock after accept. On bit_tick, go to DATA with bit index 0.
  - DATA: uart_txd = shift[idx], LSB first. On bit_tick, idx increments. After idx 7 completes, go to PARITY if PARITY_EN, else STOP.
  - PARITY: uart_txd = XOR of the 8 latched bits, XOR PARITY_ODD. On bit_tick, go to STOP.
  - STOP: uart_txd=1 for STOP_BITS bit periods. On the final bit_tick, go to IDLE and assert tx_done for that one cycle.
- tx_busy=1 in START, DATA, PARITY and STOP.
- Frame length from the first start-bit cycle to the return of tx_ready is (1+8+PARITY_EN+STOP_BITS)*BIT_CYCLES clocks: 4340 at defaults.
- Back-to-back transfers: if tx_valid is held high, the next byte is accepted on the first IDLE cycle, the same cycle tx_done pulses. The next start bit follows with zero idle gap.
- uart_txd is driven from a flop. No glitches between bits.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - the BIT_CYCLES derivation as a constant function of SYS_PERIOD/BPS;
  - the counter-width function.
- The receiver reuses the same package.
- One sub-module, uart_baud_cnt: enable input, bit_tick output, parameterised by BIT_CYCLES. The receiver instantiates the same module for its half-period sampling.

Test Plan:
- Defaults; send 0x41 -> line reads 0,1,0,0,0,0,0,1,0,1 with each level held 434 clocks. tx_done pulses 4340 clocks after the start bit begins.
- Send 0x0F, then hold tx_valid high with 0xA5 queued -> second start bit begins the cycle after the 0x0F stop bit ends. tx_ready is high for exactly one cycle between the frames.
- PARITY_EN=1, PARITY_ODD=0; send 0x07 -> parity bit=1. With PARITY_ODD=1 -> parity bit=0. Frame is 11 bit periods.
- STOP_BITS=2; send 0xFF -> start low for 434 clocks, then line high for 8+2 bit periods. tx_done is asserted at 11*434 clocks.
- Pulse tx_valid with 0x55 during the DATA phase of 0x41 -> ignored. Line carries only 0x41; only one tx_done.
- Assert rst_n=0 during data bit 3 -> uart_txd=1 and tx_ready=1 asynchronously. After release, a fresh send of 0x41 produces a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM encoding and
// bit-period derivation from the system clock and line rate.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Clocks per line bit; integer truncation of the ratio.
  function automatic int bit_cycles(input int sys_period, input int bps);
    return sys_period / bps;
  endfunction

  // Width of a counter spanning 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the last
// cycle of each period with bit_tick; parked at zero when disabled.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = cnt_width(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    bit_tick = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        bit_tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte per valid/ready handshake and shifts out
// start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SYS_PERIOD = 50000000,
  parameter int BPS        = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int   BIT_CYCLES = bit_cycles(SYS_PERIOD, BPS);
  localparam logic PAR_ODD    = (PARITY_ODD != 0);
  localparam logic STOP_LAST  = (STOP_BITS == 2);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       bit_tick;
  logic       accept;

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = !tx_ready;
  assign tx_done  = done_q;
  assign uart_txd = txd_q;
  assign accept   = tx_valid && tx_ready;

  uart_baud_cnt #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tx_busy),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = tx_data;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so it lands in a flop together
  // with the state change; no combinational path reaches the pin.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[idx_d];
      PARITY:  txd_d = (^shift_q) ^ PAR_ODD;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  // Payload register carries data only; it is always reloaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed plus randomized bench for uart_tx across four parameterisations
// (plain, even parity, odd parity, two stop bits) against a frame model.
module tb_uart_tx;

  localparam int BIT = 50000000 / 115200;
  localparam int PEN  [4] = '{0, 1, 1, 0};
  localparam int PODD [4] = '{0, 0, 1, 0};
  localparam int STP  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] valid = 4'h0;
  logic [3:0] ready, busy, done, txd;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]), .uart_txd(txd[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]), .uart_txd(txd[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]), .uart_txd(txd[2]));
  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]), .uart_txd(txd[3]));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame: bit k of the frame sent by instance i for byte b.
  function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PEN[i] != 0 && k == 9) begin
      ones = $countones(b) + PODD[i];
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  function automatic int frame_bits(input int i);
    return 1 + 8 + PEN[i] + STP[i];
  endfunction

  // Offers byte b to instance i; returns at the negedge inside the first
  // start-bit cycle with tx_valid still asserted.
  task automatic launch(input int i, input logic [7:0] b);
    for (int c = 0; c < 20000 && ready[i] !== 1'b1; c++) @(negedge clk);
    check($sformatf("ready_wait/i%0d", i), ready[i], 1'b1);
    tx_data  = b;
    valid[i] = 1'b1;
    @(negedge clk);
  endtask

  // Walks one whole frame starting at its first start-bit cycle; ends at the
  // negedge of the cycle where tx_done should be high.
  task automatic check_frame(input int i, input logic [7:0] b, input int inject_c);
    int n;
    n = frame_bits(i) * BIT;
    for (int c = 0; c < n; c++) begin
      if (inject_c >= 0 && c == inject_c) begin
        tx_data  = 8'h55;
        valid[i] = 1'b1;
      end else if (inject_c >= 0 && c == inject_c + 1) begin
        valid[i] = 1'b0;
      end
      if (c % BIT == 0 || c % BIT == BIT / 2 || c % BIT == BIT - 1)
        check($sformatf("txd/i%0d/b%02h/bit%0d/off%0d", i, b, c / BIT, c % BIT),
              txd[i], exp_bit(i, b, c / BIT));
      if (c % BIT == 0)
        check($sformatf("busy/i%0d/bit%0d", i, c / BIT), busy[i], 1'b1);
      if (c == n - 1)
        check($sformatf("done_early/i%0d", i), done[i], 1'b0);
      @(negedge clk);
    end
    check($sformatf("done_pulse/i%0d/b%02h", i, b), done[i], 1'b1);
    check($sformatf("ready_end/i%0d", i), ready[i], 1'b1);
    check($sformatf("busy_end/i%0d", i), busy[i], 1'b0);
    check($sformatf("txd_end/i%0d", i), txd[i], 1'b1);
  endtask

  task automatic post_idle(input int i);
    @(negedge clk);
    check($sformatf("done_once/i%0d", i), done[i], 1'b0);
    check($sformatf("ready_idle/i%0d", i), ready[i], 1'b1);
    check($sformatf("txd_idle/i%0d", i), txd[i], 1'b1);
  endtask

  task automatic send(input int i, input logic [7:0] b);
    launch(i, b);
    valid[i] = 1'b0;
    check_frame(i, b, -1);
    post_idle(i);
  endtask

  initial begin
    logic [7:0] r;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_txd/i%0d", i), txd[i], 1'b1);
      check($sformatf("rst_ready/i%0d", i), ready[i], 1'b1);
      check($sformatf("rst_busy/i%0d", i), busy[i], 1'b0);
      check($sformatf("rst_done/i%0d", i), done[i], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 8'h41);

    // Back-to-back: valid stays high with the next byte already presented.
    launch(0, 8'h0F);
    tx_data = 8'hA5;
    check_frame(0, 8'h0F, -1);
    @(negedge clk);
    check("b2b_ready_one_cycle", ready[0], 1'b0);
    valid[0] = 1'b0;
    check_frame(0, 8'hA5, -1);
    post_idle(0);

    // A valid pulse during the data phase must not start a second frame.
    launch(0, 8'h41);
    valid[0] = 1'b0;
    check_frame(0, 8'h41, 3 * BIT + 50);
    post_idle(0);

    send(1, 8'h07);
    send(2, 8'h07);
    send(3, 8'hFF);

    r = 8'($urandom);
    send(1, r);
    r = 8'($urandom);
    send(0, r);
    r = 8'($urandom_range(0, 255));
    send(2, r);

    // Reset in the middle of data bit 3 returns the line to idle at once.
    launch(0, 8'h41);
    valid[0] = 1'b0;
    for (int c = 0; c < 4 * BIT + 100; c++) @(negedge clk);
    check("pre_reset_bit3", txd[0], exp_bit(0, 8'h41, 4));
    check("pre_reset_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_txd", txd[0], 1'b1);
    check("async_rst_ready", ready[0], 1'b1);
    check("async_rst_busy", busy[0], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
